// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
//   fetch_state_e : fetch sequencer states (IDLE, FETCH, DRAIN)
//   NOP_INSTR     : instruction presented to decode when nothing is valid
//   PC_INCR       : sequential fetch stride in bytes
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INCR   = 4;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head, flush and count.
// Ports:
//   clk, rst (async, active-low)
//   push/push_data : write side; a push at full succeeds when a pop accompanies it
//   pop            : consume head; ignored when empty
//   flush          : drop all contents (wins over push/pop)
//   head_data      : current head entry (undefined when empty)
//   full, empty, count : occupancy status
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so push-at-full still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches to instruction memory,
// pairs in-order responses with their request PCs and buffers them for decode.
// Redirects flush everything and discard responses still in flight.
// Ports:
//   clk, rst (async, active-low)
//   imem_req_valid/ready/addr : fetch request channel
//   imem_rsp_valid/data       : in-order response channel
//   redirect_valid/pc         : control-flow redirect from decode
//   deq_ready/valid/instr/pc  : decode-side dequeue (NOP / 0 when not valid)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int               XLEN               = 64,
  parameter int               INSTRUCTION_LENGTH = 32,
  parameter int               DEPTH              = 4,
  parameter logic [XLEN-1:0]  RESET_PC           = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [XLEN-1:0]               imem_req_addr,
  input  logic                          imem_rsp_valid,
  input  logic [INSTRUCTION_LENGTH-1:0] imem_rsp_data,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          deq_ready,
  output logic                          deq_valid,
  output logic [INSTRUCTION_LENGTH-1:0] deq_instr,
  output logic [XLEN-1:0]               deq_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + INSTRUCTION_LENGTH;

  fetch_state_e      state_reg, state_next;
  logic [XLEN-1:0]   fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0]     outstanding_reg, outstanding_next;
  logic [CW-1:0]     discard_reg, discard_next;

  logic [EW-1:0]     iq_head;
  logic              iq_full, iq_empty, iq_push, iq_pop;
  logic [CW-1:0]     iq_count;
  logic [XLEN-1:0]   tag_head;
  logic              tag_full, tag_empty;
  logic [CW-1:0]     tag_count;

  logic              rsp_accept, handshake;
  logic [CW:0]       inflight;

  // Responses are only meaningful while a request is outstanding; anything
  // else (e.g. stragglers from before a reset) is ignored.
  assign rsp_accept = imem_rsp_valid && (outstanding_reg != '0);
  // Buffered entries plus requests in flight never exceed the queue size,
  // so every response is guaranteed a slot.
  assign inflight   = {1'b0, iq_count} + {1'b0, outstanding_reg};

  assign imem_req_valid = (state_reg == ST_FETCH) && !redirect_valid &&
                          (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign handshake      = imem_req_valid && imem_req_ready;

  assign iq_push   = rsp_accept && (state_reg == ST_FETCH) && !redirect_valid;
  assign deq_valid = !iq_empty && !redirect_valid;
  assign iq_pop    = deq_valid && deq_ready;
  assign deq_instr = deq_valid ? iq_head[INSTRUCTION_LENGTH-1:0]
                               : INSTRUCTION_LENGTH'(NOP_INSTR);
  assign deq_pc    = deq_valid ? iq_head[EW-1:INSTRUCTION_LENGTH] : '0;

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_q (
    .clk       (clk),
    .rst       (rst),
    .push      (iq_push),
    .push_data ({tag_head, imem_rsp_data}),
    .pop       (iq_pop),
    .flush     (redirect_valid),
    .head_data (iq_head),
    .full      (iq_full),
    .empty     (iq_empty),
    .count     (iq_count)
  );

  // Request PCs in issue order; the head pairs with the next response.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .push      (handshake),
    .push_data (fetch_pc_reg),
    .pop       (iq_push),
    .flush     (redirect_valid),
    .head_data (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, tag_full, tag_empty, tag_count, iq_full};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      fetch_pc_reg    <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;

    case (state_reg)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        outstanding_next = outstanding_reg + CW'(handshake) - CW'(rsp_accept);
        if (handshake) fetch_pc_next = fetch_pc_reg + XLEN'(PC_INCR);
      end
      ST_DRAIN: begin
        if (rsp_accept) begin
          outstanding_next = outstanding_reg - CW'(1);
          discard_next     = discard_reg - CW'(1);
          if (discard_reg == CW'(1)) state_next = ST_FETCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Redirect overrides everything: every request still in flight becomes
    // a discard, except a response landing this very cycle (dropped now).
    if (redirect_valid) begin
      fetch_pc_next    = redirect_pc;
      outstanding_next = outstanding_reg - CW'(rsp_accept);
      discard_next     = outstanding_reg - CW'(rsp_accept);
      state_next       = (outstanding_reg - CW'(rsp_accept) == '0) ? ST_FETCH : ST_DRAIN;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a 1-cycle in-order memory model plus
// a scoreboard of expected {pc, instr} entries popped on every dequeue.
module tb_fetch_queue;

  localparam int XLEN  = 64;
  localparam int IL    = 32;
  localparam int DEPTH = 4;
  localparam logic [IL-1:0] EXP_NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b1;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [IL-1:0]   imem_rsp_data = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            deq_ready = 1'b1;
  logic            deq_valid;
  logic [IL-1:0]   deq_instr;
  logic [XLEN-1:0] deq_pc;

  always #5 clk = ~clk;

  fetch_queue #(
    .XLEN(XLEN), .INSTRUCTION_LENGTH(IL), .DEPTH(DEPTH), .RESET_PC('0)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_instr(deq_instr), .deq_pc(deq_pc)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [XLEN-1:0] mem_q[$];
  logic [XLEN-1:0] exp_q[$];
  bit              mem_hold = 1'b0;

  bit              last_req_valid, last_hs, last_deq_valid, last_deq_fire;
  logic [XLEN-1:0] last_hs_addr, last_deq_pc;
  logic [IL-1:0]   last_deq_instr;

  function automatic logic [IL-1:0] mem_data(input logic [XLEN-1:0] a);
    return a[IL-1:0] ^ a[XLEN-1:XLEN-IL] ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive memory response, sample outputs #1 later,
  // update memory/scoreboard, then advance to the next falling edge.
  task automatic cycle();
    logic [XLEN-1:0] exp_pc;
    if (!mem_hold && mem_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mem_q[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    last_req_valid = imem_req_valid;
    last_hs        = imem_req_valid && imem_req_ready;
    last_hs_addr   = imem_req_addr;
    last_deq_valid = deq_valid;
    last_deq_fire  = deq_valid && deq_ready;
    last_deq_pc    = deq_pc;
    last_deq_instr = deq_instr;
    if (imem_rsp_valid) void'(mem_q.pop_front());
    if (last_hs) begin
      mem_q.push_back(imem_req_addr);
      $display("req  addr=%h", imem_req_addr);
    end
    if (redirect_valid) exp_q.delete();
    if (last_deq_fire) begin
      $display("deq  pc=%h instr=%h", deq_pc, deq_instr);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_deq: got pc=%h, required no entry", deq_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        if (deq_pc !== exp_pc || deq_instr !== mem_data(exp_pc)) begin
          miscompares++;
          $display("FAIL scoreboard_deq: got pc=%h instr=%h, required pc=%h instr=%h",
                   deq_pc, deq_instr, exp_pc, mem_data(exp_pc));
        end
      end
    end
    if (last_hs) exp_q.push_back(imem_req_addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    deq_ready = 1'b1;
    mem_hold = 1'b0;
    mem_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Let all in-flight work retire; scoreboard must end empty.
  task automatic run_drain(input string name);
    int n;
    imem_req_ready = 1'b0;
    deq_ready = 1'b1;
    mem_hold = 1'b0;
    n = 0;
    while ((mem_q.size() > 0 || exp_q.size() > 0) && n < 40) begin
      cycle();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || mem_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d entries never dequeued, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_hs(input int count, input string name);
    int n, c;
    n = 0; c = 0;
    while (n < count && c < 20) begin
      cycle();
      if (last_hs) n++;
      c++;
    end
    vectors++;
    if (n != count) begin
      miscompares++;
      $display("FAIL %s_wait_hs: got %0d handshakes, required %0d", name, n, count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors += 4;
    if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b, required 0", imem_req_valid); end
    if (deq_valid !== 1'b0) begin miscompares++; $display("FAIL reset_deq_valid: got %b, required 0", deq_valid); end
    if (deq_instr !== EXP_NOP) begin miscompares++; $display("FAIL reset_deq_instr: got %h, required %h", deq_instr, EXP_NOP); end
    if (deq_pc !== '0) begin miscompares++; $display("FAIL reset_deq_pc: got %h, required 0", deq_pc); end
    @(negedge clk);
    rst = 1'b1;
    cycle();
    vectors++;
    if (last_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_idle_req: got %b, required 0", last_req_valid); end
    cycle();
    vectors++;
    if (!(last_hs && last_hs_addr === '0)) begin
      miscompares++;
      $display("FAIL reset_first_req: got hs=%b addr=%h, required hs=1 addr=0", last_hs, last_hs_addr);
    end
  endtask

  task automatic test_stream();
    logic [XLEN-1:0] hs_addrs[$];
    logic [XLEN-1:0] pcs[$];
    logic [XLEN-1:0] got;
    int first_hs, first_dv;
    do_reset();
    first_hs = -1; first_dv = -1;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (last_hs) begin
        if (first_hs < 0) first_hs = c;
        hs_addrs.push_back(last_hs_addr);
      end
      if (last_deq_valid && first_dv < 0) first_dv = c;
      if (last_deq_fire) pcs.push_back(last_deq_pc);
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < hs_addrs.size()) ? hs_addrs[i] : '1;
      vectors++;
      if (got !== XLEN'(4 * i)) begin miscompares++; $display("FAIL stream_req_addr%0d: got %h, required %h", i, got, 4 * i); end
      got = (i < pcs.size()) ? pcs[i] : '1;
      vectors++;
      if (got !== XLEN'(4 * i)) begin miscompares++; $display("FAIL stream_deq_pc%0d: got %h, required %h", i, got, 4 * i); end
    end
    vectors++;
    if (first_dv - first_hs != 2) begin
      miscompares++;
      $display("FAIL stream_latency: got %0d cycles, required 2", first_dv - first_hs);
    end
    run_drain("stream");
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    deq_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (last_hs) n++;
    end
    vectors += 3;
    if (n != 4) begin miscompares++; $display("FAIL bp_req_count: got %0d, required 4", n); end
    if (last_req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_req_valid_full: got %b, required 0", last_req_valid); end
    if (last_deq_valid !== 1'b1) begin miscompares++; $display("FAIL bp_deq_valid_full: got %b, required 1", last_deq_valid); end
    deq_ready = 1'b1;
    wait_hs(1, "bp_resume");
    vectors++;
    if (last_hs_addr !== 64'h10) begin miscompares++; $display("FAIL bp_resume_addr: got %h, required 10", last_hs_addr); end
    run_drain("bp");
  endtask

  task automatic test_redirect_drain();
    int n;
    do_reset();
    mem_hold = 1'b1;
    wait_hs(3, "rd");
    redirect_valid = 1'b1;
    redirect_pc = 64'h100;
    cycle();
    vectors++;
    if (last_req_valid !== 1'b0) begin miscompares++; $display("FAIL rd_redirect_req: got %b, required 0", last_req_valid); end
    redirect_valid = 1'b0;
    cycle();
    vectors++;
    if (last_req_valid !== 1'b0) begin miscompares++; $display("FAIL rd_drain_hold_req: got %b, required 0", last_req_valid); end
    mem_hold = 1'b0;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (last_req_valid || last_deq_valid) n++;
    end
    vectors++;
    if (n != 0) begin miscompares++; $display("FAIL rd_drain_quiet: got %0d active cycles, required 0", n); end
    cycle();
    vectors++;
    if (!(last_hs && last_hs_addr === 64'h100)) begin
      miscompares++;
      $display("FAIL rd_next_req: got hs=%b addr=%h, required hs=1 addr=100", last_hs, last_hs_addr);
    end
    n = 0;
    while (!last_deq_fire && n < 8) begin cycle(); n++; end
    vectors++;
    if (!(last_deq_fire && last_deq_pc === 64'h100)) begin
      miscompares++;
      $display("FAIL rd_first_deq_pc: got fire=%b pc=%h, required fire=1 pc=100", last_deq_fire, last_deq_pc);
    end
    run_drain("rd");
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    mem_hold = 1'b1;
    wait_hs(3, "rr");
    imem_req_ready = 1'b0;
    mem_hold = 1'b0;
    cycle();
    redirect_valid = 1'b1;
    redirect_pc = 64'h200;
    deq_ready = 1'b1;
    cycle();
    vectors += 2;
    if (last_deq_valid !== 1'b0) begin miscompares++; $display("FAIL rr_deq_valid: got %b, required 0", last_deq_valid); end
    if (last_deq_instr !== EXP_NOP) begin miscompares++; $display("FAIL rr_deq_instr: got %h, required %h", last_deq_instr, EXP_NOP); end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    cycle();
    vectors++;
    if (last_req_valid !== 1'b0) begin miscompares++; $display("FAIL rr_drain_req: got %b, required 0", last_req_valid); end
    cycle();
    vectors++;
    if (!(last_hs && last_hs_addr === 64'h200)) begin
      miscompares++;
      $display("FAIL rr_next_req: got hs=%b addr=%h, required hs=1 addr=200", last_hs, last_hs_addr);
    end
    run_drain("rr");
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_hold = 1'b1;
    deq_ready = 1'b0;
    wait_hs(3, "rm");
    imem_req_ready = 1'b0;
    mem_hold = 1'b0;
    cycle();
    mem_hold = 1'b1;
    rst = 1'b0;
    #1;
    vectors += 4;
    if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rm_req_valid: got %b, required 0", imem_req_valid); end
    if (deq_valid !== 1'b0) begin miscompares++; $display("FAIL rm_deq_valid: got %b, required 0", deq_valid); end
    if (deq_instr !== EXP_NOP) begin miscompares++; $display("FAIL rm_deq_instr: got %h, required %h", deq_instr, EXP_NOP); end
    if (deq_pc !== '0) begin miscompares++; $display("FAIL rm_deq_pc: got %h, required 0", deq_pc); end
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    mem_hold = 1'b0;
    imem_req_ready = 1'b1;
    deq_ready = 1'b1;
    cycle();
    vectors++;
    if (last_req_valid !== 1'b0) begin miscompares++; $display("FAIL rm_idle_req: got %b, required 0", last_req_valid); end
    cycle();
    vectors++;
    if (!(last_hs && last_hs_addr === '0)) begin
      miscompares++;
      $display("FAIL rm_first_req: got hs=%b addr=%h, required hs=1 addr=0", last_hs, last_hs_addr);
    end
    run_drain("rm");
  endtask

  task automatic test_wrap();
    do_reset();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    vectors++;
    if (last_req_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_redirect_req: got %b, required 0", last_req_valid); end
    redirect_valid = 1'b0;
    cycle();
    vectors++;
    if (!(last_hs && last_hs_addr === 64'hFFFF_FFFF_FFFF_FFFC)) begin
      miscompares++;
      $display("FAIL wrap_top_req: got hs=%b addr=%h, required hs=1 addr=fffffffffffffffc", last_hs, last_hs_addr);
    end
    cycle();
    vectors++;
    if (!(last_hs && last_hs_addr === '0)) begin
      miscompares++;
      $display("FAIL wrap_zero_req: got hs=%b addr=%h, required hs=1 addr=0", last_hs, last_hs_addr);
    end
    run_drain("wrap");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_rsp();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
